mem_responder: RTL



---
 rtl/mem_responder.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the datapath Read/Write interface.
// Accepts a request, waits WAIT_STATES cycles, performs the access on an
// internal word-addressed RAM and pulses Done for one cycle.
// Optional feature macro: MEM_ERR_EN (address range check with err pulse).
module mem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 9,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  Read,
  input  logic                  Write,
  input  logic [31:0]           address,
  input  logic [DATA_WIDTH-1:0] datain,
  output logic [DATA_WIDTH-1:0] Mdatain,
  output logic                  Done,
  output logic                  busy,
  output logic                  err
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [3:0]  WS    = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    wr_q, wr_d;
  logic [DATA_WIDTH-1:0]   mdatain_q, mdatain_d;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    req;
  logic                    fire;
  logic                    eff_wr;
  logic [ADDR_WIDTH-1:0]   eff_addr;
  logic [DATA_WIDTH-1:0]   eff_data;
  logic                    eff_oor;
  logic                    mem_we;

`ifdef MEM_ERR_EN
  logic                    oor_q, oor_d;
  logic                    err_q, err_d;
`else
  logic                    unused_addr_hi;
  assign unused_addr_hi = ^address[31:ADDR_WIDTH];
`endif

  assign req = Read | Write;

  // Access operands: straight from the inputs when a zero-wait request
  // completes on its sampling edge, otherwise from the latched copies.
  always_comb begin
    if (state_q == S_IDLE) begin
      eff_wr   = Write;
      eff_addr = address[ADDR_WIDTH-1:0];
      eff_data = datain;
`ifdef MEM_ERR_EN
      eff_oor  = |address[31:ADDR_WIDTH];
`else
      eff_oor  = 1'b0;
`endif
    end else begin
      eff_wr   = wr_q;
      eff_addr = addr_q;
      eff_data = data_q;
`ifdef MEM_ERR_EN
      eff_oor  = oor_q;
`else
      eff_oor  = 1'b0;
`endif
    end
  end

  // Next-state, latch and access-strobe logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    wr_d      = wr_q;
    mdatain_d = mdatain_q;
    fire      = 1'b0;
`ifdef MEM_ERR_EN
    oor_d     = oor_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d = address[ADDR_WIDTH-1:0];
          data_d = datain;
          wr_d   = Write;
          cnt_d  = WS;
`ifdef MEM_ERR_EN
          oor_d  = |address[31:ADDR_WIDTH];
`endif
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_DONE;
            fire    = 1'b1;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_DONE;
          fire    = 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (fire && !eff_wr) begin
      mdatain_d = eff_oor ? '0 : mem[eff_addr];
    end
  end

  // A write held under clear must not reach the RAM (RAM has no reset).
  assign mem_we = fire && eff_wr && !eff_oor && !clear;

`ifdef MEM_ERR_EN
  assign err_d = fire && eff_oor;
`endif

  // Control and output registers.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      wr_q      <= 1'b0;
      mdatain_q <= '0;
`ifdef MEM_ERR_EN
      oor_q     <= 1'b0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      wr_q      <= wr_d;
      mdatain_q <= mdatain_d;
`ifdef MEM_ERR_EN
      oor_q     <= oor_d;
      err_q     <= err_d;
`endif
    end
  end

  // RAM write port; contents survive clear.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[eff_addr] <= eff_data;
    end
  end

  assign Mdatain = mdatain_q;
  assign Done    = (state_q == S_DONE);
  assign busy    = (state_q != S_IDLE);
`ifdef MEM_ERR_EN
  assign err     = err_q;
`else
  assign err     = 1'b0;
`endif

endmodule
